// File: rtl/bloco_controle_polinomio_pkg.sv
// Shared encodings for the polynomial controller: datapath select codes, ALU ops,
// FSM state encoding and the control word decoded from each state.
package bloco_controle_polinomio_pkg;

    localparam logic [1:0] M0_ZERO = 2'b00;
    localparam logic [1:0] M0_A    = 2'b01;
    localparam logic [1:0] M0_B    = 2'b10;
    localparam logic [1:0] M0_C    = 2'b11;

    localparam logic [1:0] M1_M0   = 2'b00;
    localparam logic [1:0] M1_R0   = 2'b01;
    localparam logic [1:0] M1_R2   = 2'b10;
    localparam logic [1:0] M1_R1   = 2'b11;

    localparam logic [1:0] M2_R0   = 2'b00;
    localparam logic [1:0] M2_M0   = 2'b01;
    localparam logic [1:0] M2_R2   = 2'b10;
    localparam logic [1:0] M2_R1   = 2'b11;

    localparam logic       H_MUL   = 1'b1;
    localparam logic       H_ADD   = 1'b0;

    // Each LOAD encoding is its SETUP encoding plus one.
    typedef enum logic [3:0] {
        OCIOSO     = 4'd0,
        CARGA_X    = 4'd1,
        SQ_SETUP   = 4'd2,
        SQ_LOAD    = 4'd3,
        AX2_SETUP  = 4'd4,
        AX2_LOAD   = 4'd5,
        BX_SETUP   = 4'd6,
        BX_LOAD    = 4'd7,
        SOMA_SETUP = 4'd8,
        SOMA_LOAD  = 4'd9,
        ADDC_SETUP = 4'd10,
        ADDC_LOAD  = 4'd11,
        FIM        = 4'd12
    } estado_t;

    typedef struct packed {
        logic [1:0] m0;
        logic [1:0] m1;
        logic [1:0] m2;
        logic       h;
        logic       lx;
        logic       lh;
        logic       ls;
        logic       ocupado;
        logic       fim;
    } ctrl_t;

    localparam ctrl_t CTRL_ZERO = '0;

    // Moore decode: the control word a given state presents to the datapath.
    function automatic ctrl_t decodifica(input estado_t st);
        ctrl_t c;
        c = CTRL_ZERO;
        case (st)
            CARGA_X: begin
                c.ocupado = 1'b1;
                c.lx      = 1'b1;
            end
            SQ_SETUP, SQ_LOAD: begin
                c = '{m0: M0_ZERO, m1: M1_R0, m2: M2_R0, h: H_MUL,
                      lx: 1'b0, lh: (st == SQ_LOAD), ls: 1'b0, ocupado: 1'b1, fim: 1'b0};
            end
            AX2_SETUP, AX2_LOAD: begin
                c = '{m0: M0_A, m1: M1_M0, m2: M2_R1, h: H_MUL,
                      lx: 1'b0, lh: (st == AX2_LOAD), ls: 1'b0, ocupado: 1'b1, fim: 1'b0};
            end
            BX_SETUP, BX_LOAD: begin
                c = '{m0: M0_B, m1: M1_M0, m2: M2_R0, h: H_MUL,
                      lx: 1'b0, lh: 1'b0, ls: (st == BX_LOAD), ocupado: 1'b1, fim: 1'b0};
            end
            SOMA_SETUP, SOMA_LOAD: begin
                c = '{m0: M0_ZERO, m1: M1_R2, m2: M2_R1, h: H_ADD,
                      lx: 1'b0, lh: 1'b0, ls: (st == SOMA_LOAD), ocupado: 1'b1, fim: 1'b0};
            end
            ADDC_SETUP, ADDC_LOAD: begin
                c = '{m0: M0_C, m1: M1_M0, m2: M2_R2, h: H_ADD,
                      lx: 1'b0, lh: 1'b0, ls: (st == ADDC_LOAD), ocupado: 1'b1, fim: 1'b0};
            end
            FIM: begin
                c.ocupado = 1'b1;
                c.fim     = 1'b1;
            end
            default: c = CTRL_ZERO;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/bloco_controle_polinomio_contador_espera.sv
// Settle counter for the SETUP phases; terminal flag marks the last settle cycle.
module contador_espera #(
    parameter int unsigned CNT_W         = 4,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic terminal_c
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign terminal_c = (cnt == CNT_W'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/bloco_controle_polinomio.sv
// Control FSM sequencing the polynomial datapath to compute R2 = A*x^2 + B*x + C.
// Optional stall input enabled by defining BC_HOLD_EN.
module bloco_controle_polinomio
    import bloco_controle_polinomio_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned CNT_W         = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iniciar,
`ifdef BC_HOLD_EN
    input  logic       hold,
`endif
    output logic [1:0] M0,
    output logic [1:0] M1,
    output logic [1:0] M2,
    output logic       H,
    output logic       LX,
    output logic       LH,
    output logic       LS,
    output logic       ocupado,
    output logic       fim
);

    estado_t estado, estado_d;
    ctrl_t   ctrl_q, ctrl_d;
    logic    cnt_clr, cnt_en, cnt_fim_c;

    contador_espera #(
        .CNT_W        (CNT_W),
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_contador_espera (
        .clk       (clk),
        .rst       (rst),
        .clr       (cnt_clr),
        .en        (cnt_en),
        .terminal_c(cnt_fim_c)
    );

    // Outputs are registered from the decode of the next state, so they track the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            estado <= OCIOSO;
            ctrl_q <= CTRL_ZERO;
        end else begin
            estado <= estado_d;
            ctrl_q <= ctrl_d;
        end
    end

    always_comb begin
        estado_d = estado;
        cnt_clr  = 1'b1;
        cnt_en   = 1'b0;
        ctrl_d   = CTRL_ZERO;
        case (estado)
            OCIOSO:     if (iniciar) estado_d = CARGA_X;
            CARGA_X:    estado_d = SQ_SETUP;
            SQ_SETUP, AX2_SETUP, BX_SETUP, SOMA_SETUP, ADDC_SETUP: begin
                if (cnt_fim_c) begin
                    estado_d = estado_t'(4'(estado) + 4'd1);
                end else begin
                    cnt_clr = 1'b0;
                    cnt_en  = 1'b1;
                end
            end
            SQ_LOAD:    estado_d = AX2_SETUP;
            AX2_LOAD:   estado_d = BX_SETUP;
            BX_LOAD:    estado_d = SOMA_SETUP;
            SOMA_LOAD:  estado_d = ADDC_SETUP;
            ADDC_LOAD:  estado_d = FIM;
            FIM:        estado_d = OCIOSO;
            default:    estado_d = OCIOSO;
        endcase
        ctrl_d = decodifica(estado_d);
`ifdef BC_HOLD_EN
        // Stall: keep state, counter and selects; no load strobe or fim while held.
        if (hold && (estado != OCIOSO)) begin
            estado_d   = estado;
            cnt_clr    = 1'b0;
            cnt_en     = 1'b0;
            ctrl_d     = decodifica(estado);
            ctrl_d.lx  = 1'b0;
            ctrl_d.lh  = 1'b0;
            ctrl_d.ls  = 1'b0;
            ctrl_d.fim = 1'b0;
        end
`endif
    end

    assign M0      = ctrl_q.m0;
    assign M1      = ctrl_q.m1;
    assign M2      = ctrl_q.m2;
    assign H       = ctrl_q.h;
    assign LX      = ctrl_q.lx;
    assign LH      = ctrl_q.lh;
    assign LS      = ctrl_q.ls;
    assign ocupado = ctrl_q.ocupado;
    assign fim     = ctrl_q.fim;

endmodule

// File: tb/tb_bloco_controle_polinomio.sv
// Bench: three controllers (SETTLE_CYCLES 2/1/5) each driving a behavioural 16-bit polynomial datapath.
module tb_bloco_controle_polinomio;

    localparam int B_FIM = 0;
    localparam int B_OC  = 1;
    localparam int B_LS  = 2;
    localparam int B_LH  = 3;
    localparam int B_LX  = 4;
    localparam int B_H   = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  iniciar;
`ifdef BC_HOLD_EN
    logic [2:0]  hold;
`endif
    logic [15:0] a_v, b_v, c_v, x_v;
    logic [11:0] outs_all [3];
    logic [15:0] r2_all   [3];
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int unsigned SC = (g == 0) ? 2 : ((g == 1) ? 1 : 5);
        logic [1:0]  m0, m1, m2;
        logic        h, lx, lh, ls, ocupado, fim;
        logic [15:0] r0, r1, r2, mux0, opa, opb, alu;

        bloco_controle_polinomio #(.SETTLE_CYCLES(SC), .CNT_W(4)) u_dut (
            .clk    (clk),
            .rst    (rst),
            .iniciar(iniciar[g]),
`ifdef BC_HOLD_EN
            .hold   (hold[g]),
`endif
            .M0     (m0),
            .M1     (m1),
            .M2     (m2),
            .H      (h),
            .LX     (lx),
            .LH     (lh),
            .LS     (ls),
            .ocupado(ocupado),
            .fim    (fim)
        );

        always_comb begin
            case (m0)
                2'b00:   mux0 = 16'd0;
                2'b01:   mux0 = a_v;
                2'b10:   mux0 = b_v;
                default: mux0 = c_v;
            endcase
            case (m1)
                2'b00:   opa = mux0;
                2'b01:   opa = r0;
                2'b10:   opa = r2;
                default: opa = r1;
            endcase
            case (m2)
                2'b00:   opb = r0;
                2'b01:   opb = mux0;
                2'b10:   opb = r2;
                default: opb = r1;
            endcase
            alu = h ? 16'(opa * opb) : 16'(opa + opb);
        end

        always @(posedge clk) begin
            if (lx) r0 <= x_v;
            if (lh) r1 <= alu;
            if (ls) r2 <= alu;
        end

        assign outs_all[g] = {m0, m1, m2, h, lx, lh, ls, ocupado, fim};
        assign r2_all[g]   = r2;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        iniciar = 3'b000;
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            total++;
            if (outs_all[i] !== 12'h000) begin
                bad++;
                $display("FAIL reset_hold[%0d]: got %h expected 000", i, outs_all[i]);
            end
        end
        rst = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            total++;
            if (outs_all[i] !== 12'h000) begin
                bad++;
                $display("FAIL reset_release[%0d]: got %h expected 000", i, outs_all[i]);
            end
        end
    endtask

    task automatic test_poly(input string name, input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] c, input logic [15:0] x, input logic [15:0] expv);
        int n, nlx, nlh, nls, multi;
        logic [11:0] o;
        a_v = a; b_v = b; c_v = c; x_v = x;
        iniciar[0] = 1'b1;
        step();
        iniciar[0] = 1'b0;
        n = 1; nlx = 0; nlh = 0; nls = 0; multi = 0;
        o = outs_all[0];
        while (o[B_FIM] !== 1'b1 && n < 100) begin
            nlx += int'(o[B_LX]);
            nlh += int'(o[B_LH]);
            nls += int'(o[B_LS]);
            if (int'(o[B_LX]) + int'(o[B_LH]) + int'(o[B_LS]) > 1) multi++;
            step();
            n++;
            o = outs_all[0];
        end
        total++;
        if (n != 17) begin bad++; $display("FAIL %s_latency: got %0d expected 17", name, n); end
        total++;
        if (r2_all[0] !== expv) begin bad++; $display("FAIL %s_r2: got %0d expected %0d", name, r2_all[0], expv); end
        total++;
        if (nlx != 1 || nlh != 2 || nls != 3) begin
            bad++;
            $display("FAIL %s_strobes: got lx=%0d lh=%0d ls=%0d expected 1 2 3", name, nlx, nlh, nls);
        end
        total++;
        if (multi != 0) begin bad++; $display("FAIL %s_one_strobe: got %0d cycles expected 0", name, multi); end
        total++;
        if (o[B_OC] !== 1'b1 || o[11:6] !== 6'd0) begin
            bad++; $display("FAIL %s_fim_state: got %h expected ocupado=1 selects=0", name, o);
        end
        step();
        total++;
        if (outs_all[0] !== 12'h000) begin bad++; $display("FAIL %s_after_fim: got %h expected 000", name, outs_all[0]); end
    endtask

    task automatic test_busy_ignored();
        int n;
        a_v = 16'd2; b_v = 16'd3; c_v = 16'd1; x_v = 16'd2;
        iniciar[0] = 1'b1;
        step();
        iniciar[0] = 1'b0;
        n = 1;
        while (outs_all[0][B_FIM] !== 1'b1 && n < 100) begin
            iniciar[0] = (n == 5);
            step();
            n++;
        end
        iniciar[0] = 1'b0;
        total++;
        if (n != 17) begin bad++; $display("FAIL busy_latency: got %0d expected 17", n); end
        step();
        step();
        total++;
        if (outs_all[0][B_OC] !== 1'b0) begin bad++; $display("FAIL busy_no_restart: got ocupado=%b expected 0", outs_all[0][B_OC]); end
    endtask

    task automatic test_back_to_back();
        int nf, f1, f2, w;
        logic [15:0] r2a, r2b;
        a_v = 16'd2; b_v = 16'd3; c_v = 16'd1; x_v = 16'd2;
        nf = 0; f1 = 0; f2 = 0; r2a = '0; r2b = '0;
        iniciar[0] = 1'b1;
        step();
        for (int c = 1; c <= 40; c++) begin
            if (outs_all[0][B_FIM] === 1'b1) begin
                nf++;
                if (nf == 1) begin f1 = c; r2a = r2_all[0]; end
                else if (nf == 2) begin f2 = c; r2b = r2_all[0]; end
            end
            step();
        end
        iniciar[0] = 1'b0;
        total++;
        if (nf != 2) begin bad++; $display("FAIL b2b_count: got %0d expected 2", nf); end
        total++;
        if (f1 != 17 || f2 != 35) begin bad++; $display("FAIL b2b_spacing: got %0d,%0d expected 17,35", f1, f2); end
        total++;
        if (r2a !== 16'd15 || r2b !== 16'd15) begin bad++; $display("FAIL b2b_r2: got %0d,%0d expected 15,15", r2a, r2b); end
        w = 0;
        while (outs_all[0][B_OC] !== 1'b0 && w < 60) begin step(); w++; end
        total++;
        if (outs_all[0][B_OC] !== 1'b0) begin bad++; $display("FAIL b2b_drain: got ocupado=1 expected 0"); end
    endtask

    task automatic test_settle();
        int f1, f5;
        logic [15:0] r1v, r5v;
        a_v = 16'd1; b_v = 16'd1; c_v = 16'd1; x_v = 16'd3;
        f1 = 0; f5 = 0; r1v = '0; r5v = '0;
        iniciar[2:1] = 2'b11;
        step();
        iniciar[2:1] = 2'b00;
        for (int c = 1; c <= 60; c++) begin
            if (outs_all[1][B_FIM] === 1'b1 && f1 == 0) begin f1 = c; r1v = r2_all[1]; end
            if (outs_all[2][B_FIM] === 1'b1 && f5 == 0) begin f5 = c; r5v = r2_all[2]; end
            if (f1 != 0 && f5 != 0) break;
            step();
        end
        total++;
        if (f1 != 12) begin bad++; $display("FAIL settle1_latency: got %0d expected 12", f1); end
        total++;
        if (f5 != 32) begin bad++; $display("FAIL settle5_latency: got %0d expected 32", f5); end
        total++;
        if (r1v !== 16'd13) begin bad++; $display("FAIL settle1_r2: got %0d expected 13", r1v); end
        total++;
        if (r5v !== 16'd13) begin bad++; $display("FAIL settle5_r2: got %0d expected 13", r5v); end
        step();
        step();
    endtask

    task automatic test_reset_mid();
        a_v = 16'd2; b_v = 16'd3; c_v = 16'd1; x_v = 16'd2;
        iniciar[0] = 1'b1;
        step();
        iniciar[0] = 1'b0;
        for (int n = 1; n < 5; n++) step();
        total++;
        if (outs_all[0][11:10] !== 2'b01 || outs_all[0][B_H] !== 1'b1) begin
            bad++; $display("FAIL mid_in_ax2: got %h expected M0=01 H=1", outs_all[0]);
        end
        #2 rst = 1'b0;
        #1;
        total++;
        if (outs_all[0] !== 12'h000) begin bad++; $display("FAIL mid_reset_async: got %h expected 000", outs_all[0]); end
        step();
        rst = 1'b1;
        step();
        total++;
        if (outs_all[0] !== 12'h000) begin bad++; $display("FAIL mid_reset_idle: got %h expected 000", outs_all[0]); end
    endtask

`ifdef BC_HOLD_EN
    task automatic test_hold();
        int n, lsh;
        a_v = 16'd2; b_v = 16'd3; c_v = 16'd1; x_v = 16'd2;
        iniciar[0] = 1'b1;
        step();
        iniciar[0] = 1'b0;
        for (n = 1; n < 9; n++) step();
        hold[0] = 1'b1;
        lsh = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            n++;
            lsh += int'(outs_all[0][B_LS]);
        end
        hold[0] = 1'b0;
        total++;
        if (lsh != 0) begin bad++; $display("FAIL hold_ls: got %0d pulses expected 0", lsh); end
        while (outs_all[0][B_FIM] !== 1'b1 && n < 100) begin step(); n++; end
        total++;
        if (n != 21) begin bad++; $display("FAIL hold_latency: got %0d expected 21", n); end
        total++;
        if (r2_all[0] !== 16'd15) begin bad++; $display("FAIL hold_r2: got %0d expected 15", r2_all[0]); end
        step();
    endtask
`endif

    initial begin
        rst = 1'b0;
        iniciar = 3'b000;
`ifdef BC_HOLD_EN
        hold = 3'b000;
`endif
        a_v = '0; b_v = '0; c_v = '0; x_v = '0;
        test_reset();
        test_poly("basic", 16'd2, 16'd3, 16'd1, 16'd2, 16'd15);
        test_poly("wrap", 16'd1, 16'd0, 16'd0, 16'd256, 16'd0);
        test_poly("c_only", 16'd0, 16'd0, 16'd7, 16'd9, 16'd7);
        test_busy_ignored();
        test_back_to_back();
        test_settle();
        test_reset_mid();
        test_poly("recover", 16'd2, 16'd3, 16'd1, 16'd2, 16'd15);
`ifdef BC_HOLD_EN
        test_hold();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
